// File: rtl/arbitro_contador.sv
// Purpose : round-robin owner of one shared modulo interval counter; counts 0..L-1 for the winner, then pulses Done.
// Latency : grant 1 cycle after a request is seen in IDLE, Done 1 cycle after Count=L-1, 1-cycle FIM + 1-cycle IDLE gap.
// Backpr. : none; requesters hold Req until Done (or drop it to abort), losers simply wait for the next IDLE.
//
// Ports:
//   Clock  - single clock, all updates on posedge
//   Reset  - synchronous active-low reset
//   Req    - per-requester request level
//   Len    - packed per-requester interval length, requester i at [i*W +: W]
//   Grant  - one-hot current owner, zero when idle
//   Busy   - high while an interval is running
//   Count  - current value of the shared counter
//   Done   - one-cycle completion pulse to the owner that finished
module arbitro_contador #(
  parameter int N_REQ = 4,
  parameter int W     = 3
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*W-1:0] Len,
  output logic [N_REQ-1:0]   Grant,
  output logic               Busy,
  output logic [W-1:0]       Count,
  output logic [N_REQ-1:0]   Done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIM  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [W-1:0]         len_q, len_d;
  logic [N_REQ-1:0]     grant_q, grant_d;
  logic                 busy_q, busy_d;
  logic [W-1:0]         count_q, count_d;
  logic [N_REQ-1:0]     done_q, done_d;

  // Per-requester view of the packed length bus.
  logic [W-1:0]         len_arr [N_REQ];

  always_comb begin
    for (int j = 0; j < N_REQ; j++) begin
      len_arr[j] = Len[j*W +: W];
    end
  end

  // Round-robin search: first requester strictly after last_q, wrapping.
  // The sum is one bit wider so last_q + i never overflows before the wrap.
  logic                 win_vld;
  logic [IDX_W-1:0]     win_idx;
  logic [SUM_W-1:0]     cand;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = {1'b0, last_q} + SUM_W'(i);
      if (cand >= SUM_W'(N_REQ)) begin
        cand = cand - SUM_W'(N_REQ);
      end
      if (!win_vld && Req[cand[IDX_W-1:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
  end

  // A zero length would never reach L-1, so it is promoted to a single cycle.
  logic [W-1:0] win_len;

  always_comb begin
    win_len = len_arr[win_idx];
    if (win_len == '0) begin
      win_len = W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    len_d   = len_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    count_d = count_q;
    done_d  = '0;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
        if (win_vld) begin
          state_d          = RUN;
          owner_d          = win_idx;
          len_d            = win_len;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          busy_d           = 1'b1;
        end
      end

      RUN: begin
        // Abort is checked first so a drop on the final count never yields Done.
        if (!Req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          count_d = '0;
          last_d  = owner_q;
        end else if (count_q == len_q - W'(1)) begin
          state_d         = FIM;
          done_d[owner_q] = 1'b1;
          grant_d         = '0;
          busy_d          = 1'b0;
          count_d         = '0;
          last_d          = owner_q;
        end else begin
          count_d = count_q + W'(1);
        end
      end

      FIM: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end

      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q <= IDLE;
      last_q  <= IDX_W'(N_REQ - 1);
      owner_q <= '0;
      len_q   <= W'(1);
      grant_q <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      len_q   <= len_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  assign Grant = grant_q;
  assign Busy  = busy_q;
  assign Count = count_q;
  assign Done  = done_q;

endmodule
